// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock circular-buffer FIFO with first-word-fall-through
//             read data, registered empty/full flags. Optional occupancy
//             output port `count` when FIFO_COUNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int XLEN   = 32,
    parameter int LENGTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic                      re,
    input  logic [XLEN-1:0]           din,
    output logic [XLEN-1:0]           dout,
    output logic                      empty,
`ifdef FIFO_COUNT_EN
    output logic [$clog2(LENGTH):0]   count,
`endif
    output logic                      full
);

    localparam int AW = $clog2(LENGTH);
    localparam logic [AW:0] c_full_count = (AW+1)'(LENGTH);

    logic [XLEN-1:0] r_mem [LENGTH];
    logic [AW-1:0]   frontPointer;
    logic [AW-1:0]   backPointer;
    logic [AW:0]     r_count;
    logic            r_empty;
    logic            r_full;

    logic            w_wr;
    logic            w_rd;
    logic [AW:0]     w_count_nxt;

    // Illegal operations (write when full, read when empty) are dropped here.
    assign w_wr = we & ~r_full;
    assign w_rd = re & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frontPointer <= '0;
            backPointer  <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
        end else begin
            if (w_wr) begin
                backPointer <= backPointer + 1'b1;
            end
            if (w_rd) begin
                frontPointer <= frontPointer + 1'b1;
            end
            r_count <= w_count_nxt;
            // Flags come from the next occupancy so they are valid right after the edge.
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_full_count);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[backPointer] <= din;
        end
    end

    assign dout  = r_mem[frontPointer];
    assign empty = r_empty;
    assign full  = r_full;

`ifdef FIFO_COUNT_EN
    assign count = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo
//  Brief    : Directed self-checking bench for sync_fifo (depth 4, 32 bits).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    logic        clk;
    logic        reset;
    logic        we;
    logic        re;
    logic [31:0] din;
    logic [31:0] dout;
    logic        empty;
    logic        full;
`ifdef FIFO_COUNT_EN
    logic [2:0]  count;
`endif

    int n_checks;
    int n_fail;

    sync_fifo #(
        .XLEN   (32),
        .LENGTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .re    (re),
        .din   (din),
        .dout  (dout),
        .empty (empty),
`ifdef FIFO_COUNT_EN
        .count (count),
`endif
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] fp, input logic [1:0] bp,
                             input logic e, input logic f);
        chk({tag, ".front"}, 32'(dut.frontPointer), 32'(fp));
        chk({tag, ".back"},  32'(dut.backPointer),  32'(bp));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"},  32'(full),  32'(f));
    endtask

    logic [31:0] wvals [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        we    = 1'b0;
        re    = 1'b0;
        din   = '0;
        wvals[0] = 32'hdeadbeef;
        wvals[1] = 32'hbababebe;
        wvals[2] = 32'hcacacaca;
        wvals[3] = 32'hfeedbeef;
        #12;
        reset = 1'b0;
        step();
        chk_state("reset", 2'd0, 2'd0, 1'b1, 1'b0);

        // Read on an empty FIFO is ignored
        re = 1'b1;
        step();
        re = 1'b0;
        chk_state("rd_empty", 2'd0, 2'd0, 1'b1, 1'b0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            we  = 1'b1;
            din = wvals[i];
            step();
            chk_state($sformatf("wr%0d", i), 2'd0, 2'(i + 1), 1'b0, (i == 3));
            chk($sformatf("wr%0d.dout", i), dout, 32'hdeadbeef);
        end

        // Write when full is dropped
        din = 32'h00000000;
        step();
        we = 1'b0;
        chk_state("wr_full", 2'd0, 2'd0, 1'b0, 1'b1);
        chk("wr_full.dout", dout, 32'hdeadbeef);

        // Three pops, data valid before each edge
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pop%0d.dout", i), dout, wvals[i]);
            step();
        end
        re = 1'b0;
        chk("pop_last.dout", dout, 32'hfeedbeef);
        chk_state("pop3", 2'd3, 2'd0, 1'b0, 1'b0);

        // Simultaneous read/write with one entry held
        re  = 1'b1;
        we  = 1'b1;
        din = 32'h01010101;
        step();
        we = 1'b0;
        chk("rw1.dout", dout, 32'h01010101);
        chk_state("rw1", 2'd0, 2'd1, 1'b0, 1'b0);
        step();
        re = 1'b0;
        chk_state("drain", 2'd1, 2'd1, 1'b1, 1'b0);

        // Read on empty after wrap leaves pointer in place
        re = 1'b1;
        step();
        re = 1'b0;
        chk_state("rd_empty2", 2'd1, 2'd1, 1'b1, 1'b0);

        // Simultaneous write+read on empty: only the write happens
        we  = 1'b1;
        re  = 1'b1;
        din = 32'h12345678;
        step();
        we = 1'b0;
        re = 1'b0;
        chk_state("rw_empty", 2'd1, 2'd2, 1'b0, 1'b0);
        chk("rw_empty.dout", dout, 32'h12345678);

        // Second entry, then async reset between edges
        we  = 1'b1;
        din = 32'h87654321;
        step();
        we = 1'b0;
        chk_state("two_held", 2'd1, 2'd3, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_state("async_rst", 2'd0, 2'd0, 1'b1, 1'b0);
        #1;
        reset = 1'b0;
        step();
        chk_state("post_rst", 2'd0, 2'd0, 1'b1, 1'b0);

        // Fill, then simultaneous read/write while full: write dropped
        we = 1'b1;
        din = 32'h11; step();
        din = 32'h22; step();
        din = 32'h33; step();
        din = 32'h44; step();
        chk_state("refill", 2'd0, 2'd0, 1'b0, 1'b1);
        re  = 1'b1;
        din = 32'h55;
        step();
        re = 1'b0;
        chk_state("rw_full", 2'd1, 2'd0, 1'b0, 1'b0);
        chk("rw_full.dout", dout, 32'h22);
        din = 32'h66;
        step();
        we = 1'b0;
        chk_state("refull", 2'd1, 2'd1, 1'b0, 1'b1);

        // Drain: 0x55 must not appear
        re = 1'b1;
        chk("drain0", dout, 32'h22); step();
        chk("drain1", dout, 32'h33); step();
        chk("drain2", dout, 32'h44); step();
        chk("drain3", dout, 32'h66); step();
        re = 1'b0;
        chk_state("drained", 2'd1, 2'd1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
